// File: rtl/ex_block_mc.sv
// ex_block_mc - multi-cycle execution block.
//
// Executes the 6-bit op_dec instruction set at WIDTH bits. The result is
// registered. Valid/ready handshakes sit on both the input and output sides.
// MUL is a shift-add over WIDTH cycles. Variable shifts are either iterative,
// one bit per cycle, or a single-cycle barrel shift, chosen by FAST_SHIFT.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid        op_dec/A/B/data_in valid
//   in_ready        block accepts an op this cycle
//   op_dec          6-bit opcode
//   A, B            operands (B also address / shift amount / branch target)
//   data_in         immediate for 001xxx ops, IN port data
//   out_valid       result registers valid
//   out_ready       downstream consumes the result
//   ans_ex          result / address / target
//   DM_data         store data (ST)
//   data_out        output-port register (OUT)
//   flag_ex         {carry, zero} flag register
//   branch_taken    branch decision, qualified by out_valid
//   halted          sticky after HLT
module ex_block_mc #(
    parameter int WIDTH      = 16,
    parameter int FAST_SHIFT = 0,
    parameter int SHW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op_dec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] DM_data,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       flag_ex,
    output logic             branch_taken,
    output logic             halted
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001,
                           OP_MOV = 6'b000010, OP_MUL = 6'b000011,
                           OP_AND = 6'b000100, OP_OR  = 6'b000101,
                           OP_XOR = 6'b000110, OP_NOT = 6'b000111,
                           OP_ADI = 6'b001000, OP_SBI = 6'b001001,
                           OP_MVI = 6'b001010, OP_ANI = 6'b001100,
                           OP_ORI = 6'b001101, OP_XRI = 6'b001110,
                           OP_NTI = 6'b001111, OP_RET = 6'b010000,
                           OP_HLT = 6'b010001, OP_ST  = 6'b010100,
                           OP_LD  = 6'b010101, OP_IN  = 6'b010110,
                           OP_OUT = 6'b010111, OP_JMP = 6'b011000,
                           OP_LS  = 6'b011001, OP_RS  = 6'b011010,
                           OP_RSA = 6'b011011, OP_JC  = 6'b011100,
                           OP_JNC = 6'b011101, OP_JZ  = 6'b011110,
                           OP_JNZ = 6'b011111;

    // Flag update modes applied at completion.
    localparam logic [1:0] F_KEEP = 2'd0, F_CZ = 2'd1, F_ZC = 2'd2;

    typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic [5:0]         op_r;
    logic [2*WIDTH-1:0] acc;      // {partial product, remaining multiplier}
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   sh;
    logic [CW-1:0]      cnt;

    logic               accept, is_shift, shift_iter, last;
    logic [WIDTH-1:0]   bsel;
    logic [SHW-1:0]     amt;

    function automatic logic [1:0] next_flags(input logic [1:0]       mode,
                                              input logic             c,
                                              input logic [WIDTH-1:0] r,
                                              input logic [1:0]       cur);
        logic [1:0] f;
        case (mode)
            F_CZ:    f = {c, (r == '0)};
            F_ZC:    f = {1'b0, (r == '0)};
            default: f = cur;
        endcase
        return f;
    endfunction

    // DONE is treated like IDLE for acceptance so a new op can be taken in
    // the same cycle the held result is consumed.
    assign out_valid  = (state == DONE);
    assign in_ready   = ((state == IDLE) || (state == DONE)) && !halted &&
                        (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign bsel       = (op_dec[5:3] == 3'b001) ? data_in : B;
    assign amt        = B[SHW-1:0];
    assign is_shift   = (op_dec == OP_LS) || (op_dec == OP_RS) || (op_dec == OP_RSA);
    assign shift_iter = is_shift && (FAST_SHIFT == 0) && (amt != '0);
    assign last       = (cnt == CW'(1));

    // Barrel shifter: one extra bit beyond the word captures the last bit
    // shifted out, and is naturally 0 when the amount is 0.
    logic [WIDTH:0]        lext, rext, aext;
    logic signed [WIDTH:0] sext;
    always_comb begin
        lext = {1'b0, A} << amt;
        rext = {A, 1'b0} >> amt;
        sext = {A, 1'b0};
        aext = sext >>> amt;
    end

    logic [WIDTH-1:0] sc_ans;
    logic             sc_c, sc_br, sc_st, sc_out, sc_hlt;
    logic [1:0]       sc_fmode;
    logic [WIDTH:0]   ext;
    always_comb begin
        sc_ans   = '0;
        sc_c     = 1'b0;
        sc_fmode = F_KEEP;
        sc_br    = 1'b0;
        sc_st    = 1'b0;
        sc_out   = 1'b0;
        sc_hlt   = 1'b0;
        ext      = '0;
        case (op_dec)
            OP_ADD, OP_ADI: begin
                ext = {1'b0, A} + {1'b0, bsel};
                sc_ans = ext[WIDTH-1:0]; sc_c = ext[WIDTH]; sc_fmode = F_CZ;
            end
            OP_SUB, OP_SBI: begin
                ext = {1'b0, A} - {1'b0, bsel};
                sc_ans = ext[WIDTH-1:0]; sc_c = ext[WIDTH]; sc_fmode = F_CZ;
            end
            OP_MOV, OP_MVI: sc_ans = bsel;
            OP_AND, OP_ANI: begin sc_ans = A & bsel; sc_fmode = F_ZC; end
            OP_OR,  OP_ORI: begin sc_ans = A | bsel; sc_fmode = F_ZC; end
            OP_XOR, OP_XRI: begin sc_ans = A ^ bsel; sc_fmode = F_ZC; end
            OP_NOT, OP_NTI: begin sc_ans = ~bsel;    sc_fmode = F_ZC; end
            OP_LS:  begin sc_ans = lext[WIDTH-1:0]; sc_c = lext[WIDTH]; sc_fmode = F_CZ; end
            OP_RS:  begin sc_ans = rext[WIDTH:1];   sc_c = rext[0];     sc_fmode = F_CZ; end
            OP_RSA: begin sc_ans = aext[WIDTH:1];   sc_c = aext[0];     sc_fmode = F_CZ; end
            OP_RET, OP_JMP: begin sc_ans = B; sc_br = 1'b1; end
            OP_JC:  begin sc_ans = B; sc_br = flag_ex[1];  end
            OP_JNC: begin sc_ans = B; sc_br = !flag_ex[1]; end
            OP_JZ:  begin sc_ans = B; sc_br = flag_ex[0];  end
            OP_JNZ: begin sc_ans = B; sc_br = !flag_ex[0]; end
            OP_ST:  begin sc_ans = B; sc_st = 1'b1; end
            OP_LD:  sc_ans = B;
            OP_IN:  sc_ans = data_in;
            OP_OUT: sc_out = 1'b1;
            OP_HLT: sc_hlt = 1'b1;
            default: sc_ans = '0;
        endcase
    end

    // One iteration step for MUL and for the iterative shifter.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_c;
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        case (op_r)
            OP_LS:   begin sh_next = {sh[WIDTH-2:0], 1'b0};      sh_c = sh[WIDTH-1]; end
            OP_RS:   begin sh_next = {1'b0, sh[WIDTH-1:1]};      sh_c = sh[0];       end
            default: begin sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]}; sh_c = sh[0];     end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (op_dec == OP_MUL) state_next = MUL;
                    else if (shift_iter)  state_next = SHIFT;
                    else                  state_next = DONE;
                end else if ((state == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            MUL:     if (last) state_next = DONE;
            SHIFT:   if (last) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= '0;
            acc          <= '0;
            mcand        <= '0;
            sh           <= '0;
            cnt          <= '0;
            ans_ex       <= '0;
            DM_data      <= '0;
            data_out     <= '0;
            flag_ex      <= '0;
            branch_taken <= 1'b0;
            halted       <= 1'b0;
        end else if (accept) begin
            op_r <= op_dec;
            if (op_dec == OP_MUL) begin
                acc   <= {{WIDTH{1'b0}}, B};
                mcand <= A;
                cnt   <= CW'(WIDTH);
            end else if (shift_iter) begin
                sh  <= A;
                cnt <= CW'(amt);
            end else begin
                ans_ex       <= sc_ans;
                branch_taken <= sc_br;
                flag_ex      <= next_flags(sc_fmode, sc_c, sc_ans, flag_ex);
                if (sc_st)  DM_data  <= A;
                if (sc_out) data_out <= A;
                if (sc_hlt) halted   <= 1'b1;
            end
        end else if (state == MUL) begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
            if (last) begin
                ans_ex       <= mul_next[WIDTH-1:0];
                flag_ex      <= next_flags(F_CZ, |mul_next[2*WIDTH-1:WIDTH],
                                           mul_next[WIDTH-1:0], flag_ex);
                branch_taken <= 1'b0;
            end
        end else if (state == SHIFT) begin
            sh  <= sh_next;
            cnt <= cnt - CW'(1);
            if (last) begin
                ans_ex       <= sh_next;
                flag_ex      <= next_flags(F_CZ, sh_c, sh_next, flag_ex);
                branch_taken <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_block_mc.sv
module tb_ex_block_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]   op_dec;
    logic [W-1:0] A, B, data_in, ans_ex, DM_data, data_out;
    logic [1:0]   flag_ex;
    logic         branch_taken, halted;

    logic         f_in_valid, f_in_ready, f_out_valid, f_branch, f_halted;
    logic [5:0]   f_op;
    logic [W-1:0] f_A, f_B, f_ans, f_dm, f_dout;
    logic [1:0]   f_flag;

    ex_block_mc #(.WIDTH(W), .FAST_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_dec(op_dec), .A(A), .B(B), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .ans_ex(ans_ex),
        .DM_data(DM_data), .data_out(data_out), .flag_ex(flag_ex),
        .branch_taken(branch_taken), .halted(halted));

    ex_block_mc #(.WIDTH(W), .FAST_SHIFT(1)) dut_fast (
        .clk(clk), .reset(reset), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .op_dec(f_op), .A(f_A), .B(f_B), .data_in('0),
        .out_valid(f_out_valid), .out_ready(1'b1), .ans_ex(f_ans),
        .DM_data(f_dm), .data_out(f_dout), .flag_ex(f_flag),
        .branch_taken(f_branch), .halted(f_halted));

    typedef struct {
        logic [W-1:0] ans;
        logic         chk_ans;
        logic [1:0]   flags;
        logic         br;
        logic [W-1:0] dm;
        logic         chk_dm;
        logic [W-1:0] dout;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           errors = 0, checks = 0, cyc = 0;
    bit           seen = 0, rdy_rand = 0;
    logic [1:0]   m_flags = 2'b00;
    logic [W-1:0] m_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural effect of one op from its rules.
    function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a, b, din,
                                   input logic [1:0] fl, input logic [W-1:0] dout_in,
                                   input bit fast);
        exp_t e;
        logic [W-1:0] bs, r;
        logic signed [W-1:0] sa;
        int amt, s;
        longint p;
        bs = (op[5:3] == 3'b001) ? din : b;
        amt = int'(b[3:0]);
        e.ans = '0; e.chk_ans = 1; e.flags = fl; e.br = 0; e.dm = '0; e.chk_dm = 0;
        e.dout = dout_in; e.lat = 1; e.acc = 0;
        case (op)
            6'b000000, 6'b001000: begin
                s = int'(a) + int'(bs); e.ans = s[W-1:0];
                e.flags = {s > 65535, e.ans == 0};
            end
            6'b000001, 6'b001001: begin
                e.ans = a - bs; e.flags = {a < bs, a == bs};
            end
            6'b000010, 6'b001010: e.ans = bs;
            6'b000011: begin
                p = longint'(a) * longint'(b); e.ans = p[W-1:0];
                e.flags = {p > 65535, e.ans == 0}; e.lat = W + 1;
            end
            6'b000100, 6'b001100: begin e.ans = a & bs; e.flags = {1'b0, e.ans == 0}; end
            6'b000101, 6'b001101: begin e.ans = a | bs; e.flags = {1'b0, e.ans == 0}; end
            6'b000110, 6'b001110: begin e.ans = a ^ bs; e.flags = {1'b0, e.ans == 0}; end
            6'b000111, 6'b001111: begin e.ans = ~bs;    e.flags = {1'b0, e.ans == 0}; end
            6'b011001, 6'b011010, 6'b011011: begin
                if (amt == 0) begin
                    e.ans = a; e.flags = {1'b0, a == 0};
                end else begin
                    sa = a;
                    if (op == 6'b011001) begin r = a << amt; e.flags[1] = a[W-amt]; end
                    else if (op == 6'b011010) begin r = a >> amt; e.flags[1] = a[amt-1]; end
                    else begin r = sa >>> amt; e.flags[1] = a[amt-1]; end
                    e.ans = r; e.flags[0] = (r == 0);
                    e.lat = fast ? 1 : amt + 1;
                end
            end
            6'b010000, 6'b011000: begin e.ans = b; e.br = 1; end
            6'b011100: begin e.ans = b; e.br = fl[1];  end
            6'b011101: begin e.ans = b; e.br = !fl[1]; end
            6'b011110: begin e.ans = b; e.br = fl[0];  end
            6'b011111: begin e.ans = b; e.br = !fl[0]; end
            6'b010100: begin e.ans = b; e.dm = a; e.chk_dm = 1; end
            6'b010101: e.ans = b;
            6'b010110: e.ans = din;
            6'b010111: begin e.dout = a; e.chk_ans = 0; end
            6'b010001: e.chk_ans = 0;
            default:   e.ans = '0;
        endcase
        return e;
    endfunction

    // Monitor: compares the head expectation while a result is presented.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1;
                    chk("latency", cyc - q[0].acc, q[0].lat);
                end
                if (q[0].chk_ans) chk("ans_ex", ans_ex, q[0].ans);
                chk("flag_ex", flag_ex, q[0].flags);
                chk("branch_taken", branch_taken, q[0].br);
                chk("data_out", data_out, q[0].dout);
                if (q[0].chk_dm) chk("DM_data", DM_data, q[0].dm);
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called in the post-edge phase; returns in the post-edge phase after accept.
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, b, din);
        exp_t e;
        bit ok;
        ok = 0;
        in_valid = 1; op_dec = op; A = a; B = b; data_in = din;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(op, a, b, din, m_flags, m_dout, 0);
                e.acc = cyc;
                m_flags = e.flags; m_dout = e.dout;
                q.push_back(e);
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        op_dec = 6'($urandom); A = W'($urandom); B = W'($urandom); data_in = W'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic fast_op(input logic [5:0] op, input logic [W-1:0] a, b);
        exp_t e;
        e = model(op, a, b, '0, f_flag, '0, 1);
        f_in_valid = 1; f_op = op; f_A = a; f_B = b;
        @(negedge clk);
        chk("fast_in_ready", f_in_ready, 1'b1);
        @(posedge clk); #1;
        f_in_valid = 0; f_A = W'($urandom); f_B = W'($urandom);
        @(negedge clk);
        chk("fast_out_valid_lat1", f_out_valid, 1'b1);
        chk("fast_ans", f_ans, e.ans);
        chk("fast_flag", f_flag, e.flags);
        @(posedge clk); #1;
    endtask

    logic [5:0] ops[26] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
                            6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
                            6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                            6'b010000, 6'b010100, 6'b010101, 6'b010110, 6'b010111,
                            6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b011100,
                            6'b011110};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; op_dec = '0; A = '0; B = '0; data_in = '0;
        f_in_valid = 0; f_op = '0; f_A = '0; f_B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ans", ans_ex, '0);
        chk("rst_flags", flag_ex, 2'b00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_data_out", data_out, '0);
        reset = 0;

        // Directed cases
        issue(6'b000000, 16'h0040, 16'h00C0, 16'h0);
        issue(6'b000001, 16'h0040, 16'h0040, 16'h0);
        issue(6'b000000, 16'hFFFF, 16'h0001, 16'h0);
        issue(6'b011100, 16'h0000, 16'h0123, 16'h0);
        issue(6'b011101, 16'h0000, 16'h0123, 16'h0);
        issue(6'b000011, 16'h0012, 16'h0034, 16'h0);
        // in_ready must stay low while the MUL iterates
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mul_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        issue(6'b000011, 16'h0100, 16'h0100, 16'h0);
        issue(6'b011011, 16'h80C0, 16'h0004, 16'h0);
        issue(6'b011001, 16'h80C0, 16'h0000, 16'h0);
        issue(6'b001000, 16'h1234, 16'hFFFF, 16'h0011);
        issue(6'b010100, 16'hBEEF, 16'h0200, 16'h0);
        issue(6'b010111, 16'hCAFE, 16'h0000, 16'h0);
        issue(6'b010110, 16'h0000, 16'h0000, 16'h5A5A);
        issue(6'b100000, 16'h1111, 16'h2222, 16'h3333);
        drain();

        // Backpressure: result held, pending op refused, then back-to-back accept
        out_ready = 0;
        issue(6'b000000, 16'h0003, 16'h0004, 16'h0);
        in_valid = 1; op_dec = 6'b000000; A = 16'h0001; B = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_ans_stable", ans_ex, 16'h0007);
            @(posedge clk); #1;
        end
        out_ready = 1;
        issue(6'b000000, 16'h0001, 16'h0002, 16'h0);
        drain();

        // Randomized traffic with random downstream backpressure
        rdy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            logic [W-1:0] b;
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 25)];
            if (op == 6'b010001) op = 6'b000000;
            b = W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            issue(op, W'($urandom), b, W'($urandom));
        end
        drain();
        rdy_rand = 0;
        @(posedge clk); #1;
        out_ready = 1;

        // Reset in the middle of a MUL
        issue(6'b000011, 16'h1234, 16'h5678, 16'h0);
        repeat (7) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        q.delete(); seen = 0; m_flags = 2'b00; m_dout = '0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_flags", flag_ex, 2'b00);
        chk("midrst_in_ready", in_ready, 1'b1);
        repeat (20) begin
            @(negedge clk);
            chk("midrst_no_result", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        issue(6'b000000, 16'h0101, 16'h0202, 16'h0);
        drain();

        // Halt is sticky until reset
        issue(6'b010001, 16'h0, 16'h0, 16'h0);
        drain();
        in_valid = 1; op_dec = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_halted", halted, 1'b1);
            chk("halt_in_ready", in_ready, 1'b0);
            chk("halt_no_accept", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("halt_cleared", halted, 1'b0);
        chk("halt_reset_in_ready", in_ready, 1'b1);

        // Barrel-shift variant: same results, single-cycle latency
        fast_op(6'b011011, 16'h80C0, 16'h0004);
        fast_op(6'b011001, 16'h80C0, 16'h0000);
        for (int i = 0; i < 20; i++)
            fast_op(6'b011001 + 6'($urandom_range(0, 2)), W'($urandom), W'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
